// File: rtl/tone_pkg.sv
`default_nettype none
// ==== tone_pkg : shared types, defaults and helpers for the tone sequencer ==== rev 1.0
package tone_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2
  } state_e;

  localparam int DEF_CLK_HZ  = 25000000;
  localparam int DEF_TICK_HZ = 100;
  localparam int DEF_DIV_W   = 16;
  localparam int DEF_DUR_W   = 8;
  localparam int DEF_NOTES   = 16;

  // Half-period divider value producing a tone of 'hz' from a clk_hz clock.
  function automatic int hz_to_div(input int clk_hz, input int hz);
    return clk_hz / (2 * hz);
  endfunction

endpackage
`default_nettype wire

// File: rtl/tone_divider.sv
`default_nettype none
// ==== tone_divider : square-wave generator, half-period = div cycles, div 0 = rest ==== rev 1.0
module tone_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [DIV_W-1:0] div,
  input  logic             enable,
  output logic             speaker
);

  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] cnt_q;
  logic             spk_q;

  // div is latched on load so table rewrites never disturb the note in progress.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_q <= '0;
      cnt_q <= '0;
      spk_q <= 1'b0;
    end else if (load) begin
      div_q <= div;
      cnt_q <= div - DIV_ONE;
      spk_q <= 1'b0;
    end else if (enable && (div_q != '0)) begin
      if (cnt_q == '0) begin
        spk_q <= ~spk_q;
        cnt_q <= div_q - DIV_ONE;
      end else begin
        cnt_q <= cnt_q - DIV_ONE;
      end
    end else begin
      spk_q <= 1'b0;
    end
  end

  assign speaker = spk_q;

endmodule
`default_nettype wire

// File: rtl/tone_sequencer.sv
`default_nettype none
// ==== tone_sequencer : note-table driven tone player (IDLE/LOAD/PLAY) ==== rev 1.0
module tone_sequencer
  import tone_pkg::*;
#(
  parameter int CLK_HZ  = DEF_CLK_HZ,
  parameter int TICK_HZ = DEF_TICK_HZ,
  parameter int DIV_W   = DEF_DIV_W,
  parameter int DUR_W   = DEF_DUR_W,
  parameter int NOTES   = DEF_NOTES
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     loop_en,
  input  logic                     wr_en,
  input  logic [$clog2(NOTES)-1:0] wr_addr,
  input  logic [DIV_W-1:0]         wr_div,
  input  logic [DUR_W-1:0]         wr_dur,
  output logic                     busy,
  output logic [$clog2(NOTES)-1:0] note_idx,
  output logic                     speaker
);

  localparam int AW       = $clog2(NOTES);
  localparam int TICK_DIV = CLK_HZ / TICK_HZ;
  localparam int PW       = $clog2(TICK_DIV);

  localparam logic [PW-1:0]    PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [DUR_W-1:0] DUR_ONE  = DUR_W'(1);
  localparam logic [AW-1:0]    IDX_LAST = AW'(NOTES - 1);
  localparam logic [AW-1:0]    IDX_ONE  = AW'(1);

  logic [DIV_W-1:0] div_mem_q [NOTES];
  logic [DUR_W-1:0] dur_mem_q [NOTES];

  state_e           state_q;
  logic [AW-1:0]    idx_q;
  logic [PW-1:0]    pre_q;
  logic [DUR_W-1:0] dur_q;
  logic             busy_q;

  logic [DIV_W-1:0] entry_div;
  logic [DUR_W-1:0] entry_dur;
  logic             tick_wrap;
  logic             note_done;
  logic             div_load;
  logic             div_enable;

  // Table has no reset: contents survive rst_n and stop.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      div_mem_q[wr_addr] <= wr_div;
      dur_mem_q[wr_addr] <= wr_dur;
    end
  end

  assign entry_div  = div_mem_q[idx_q];
  assign entry_dur  = dur_mem_q[idx_q];
  assign tick_wrap  = (pre_q == PRE_LAST);
  assign note_done  = (state_q == ST_PLAY) && tick_wrap && (dur_q == DUR_ONE);
  assign div_load   = (state_q == ST_LOAD) && !stop && (entry_dur != '0);
  assign div_enable = (state_q == ST_PLAY) && !stop && !note_done;

  always_ff @(posedge clk) begin
    if (!rst_n || stop) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      pre_q   <= '0;
      dur_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LOAD;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (entry_dur != '0) begin
            state_q <= ST_PLAY;
            pre_q   <= '0;
            dur_q   <= entry_dur;
          end else if (loop_en && (idx_q != '0)) begin
            idx_q <= '0;
          end else begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
          end
        end
        ST_PLAY: begin
          if (tick_wrap) begin
            pre_q <= '0;
            dur_q <= dur_q - DUR_ONE;
            if (dur_q == DUR_ONE) begin
              // The last table slot behaves like an end marker on expiry.
              if (idx_q != IDX_LAST) begin
                state_q <= ST_LOAD;
                idx_q   <= idx_q + IDX_ONE;
              end else if (loop_en) begin
                state_q <= ST_LOAD;
                idx_q   <= '0;
              end else begin
                state_q <= ST_IDLE;
                idx_q   <= '0;
                busy_q  <= 1'b0;
              end
            end
          end else begin
            pre_q <= pre_q + PRE_ONE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  tone_divider #(
    .DIV_W(DIV_W)
  ) u_divider (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (div_load),
    .div    (entry_div),
    .enable (div_enable),
    .speaker(speaker)
  );

  assign busy     = busy_q;
  assign note_idx = idx_q;

endmodule
`default_nettype wire

// File: tb/tb_tone_sequencer.sv
`default_nettype none
// ==== tb_tone_sequencer : randomized bench against a note-level reference model ==== rev 1.0
module tb_tone_sequencer;

  localparam int CLK_HZ  = 1000;
  localparam int TICK_HZ = 100;
  localparam int TD      = CLK_HZ / TICK_HZ;
  localparam int NOTES   = 4;
  localparam int AW      = 2;
  localparam int DIV_W   = 8;
  localparam int DUR_W   = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             stop = 1'b0;
  logic             loop_en = 1'b0;
  logic             wr_en = 1'b0;
  logic [AW-1:0]    wr_addr = '0;
  logic [DIV_W-1:0] wr_div = '0;
  logic [DUR_W-1:0] wr_dur = '0;
  logic             busy;
  logic [AW-1:0]    note_idx;
  logic             speaker;

  always #5 clk = ~clk;

  tone_sequencer #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ),
    .DIV_W  (DIV_W),
    .DUR_W  (DUR_W),
    .NOTES  (NOTES)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .stop    (stop),
    .loop_en (loop_en),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_div  (wr_div),
    .wr_dur  (wr_dur),
    .busy    (busy),
    .note_idx(note_idx),
    .speaker (speaker)
  );

  int n_err = 0;
  int n_chk = 0;

  // Reference model: a note is one LOAD cycle followed by dur*TD PLAY cycles,
  // during which the speaker level is floor(k/div) mod 2.
  int m_tdiv [NOTES];
  int m_tdur [NOTES];
  int m_phase = 0;  // 0 idle, 1 load, 2 play
  int m_idx = 0;
  bit m_idx_valid = 1'b1;
  int m_k = 0;
  int m_len = 0;
  int m_div = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_step();
    if (!rst_n || stop) begin
      m_phase = 0; m_idx = 0; m_idx_valid = 1'b1;
    end else begin
      case (m_phase)
        0: if (start) begin m_phase = 1; m_idx = 0; m_idx_valid = 1'b1; end
        1: begin
          if (m_tdur[m_idx] != 0) begin
            m_phase = 2; m_div = m_tdiv[m_idx]; m_len = m_tdur[m_idx] * TD; m_k = 0;
          end else if (loop_en && m_idx != 0) begin
            m_idx = 0;
          end else begin
            m_phase = 0; m_idx_valid = 1'b0;
          end
        end
        default: begin
          m_k++;
          if (m_k == m_len) begin
            if (m_idx < NOTES - 1) begin m_phase = 1; m_idx++; end
            else if (loop_en) begin m_phase = 1; m_idx = 0; end
            else begin m_phase = 0; m_idx_valid = 1'b0; end
          end
        end
      endcase
    end
    if (wr_en) begin
      m_tdiv[wr_addr] = int'(wr_div);
      m_tdur[wr_addr] = int'(wr_dur);
    end
  endfunction

  function automatic int exp_spk();
    if (m_phase == 2 && m_div != 0) return (m_k / m_div) % 2;
    return 0;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("busy", 32'(busy), (m_phase != 0) ? 32'd1 : 32'd0);
    check_val("speaker", 32'(speaker), 32'(exp_spk()));
    if (m_idx_valid) check_val("note_idx", 32'(note_idx), 32'(m_idx));
  endtask

  task automatic write_entry(input int a, input int d, input int u);
    wr_en = 1'b1; wr_addr = AW'(a); wr_div = DIV_W'(d); wr_dur = DUR_W'(u);
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_table_a();
    write_entry(0, 3, 2);
    write_entry(1, 0, 1);
    write_entry(2, 5, 0);
    write_entry(3, 2, 1);
  endtask

  task automatic run_until_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin tick(); n++; end
    check_val("idle_reached", 32'(busy), 32'd0);
  endtask

  task automatic play_count(output int bc);
    start = 1'b1; tick(); start = 1'b0;
    bc = busy ? 1 : 0;
    for (int i = 0; i < 39; i++) begin tick(); if (busy) bc++; end
  endtask

  initial begin
    int bc, last, wraps, prev, seen3, n;
    for (int i = 0; i < NOTES; i++) begin m_tdiv[i] = 0; m_tdur[i] = 0; end

    repeat (3) tick();
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_idx", 32'(note_idx), 32'd0);
    check_val("rst_spk", 32'(speaker), 32'd0);
    rst_n = 1'b1;
    tick();
    load_table_a();

    // Basic sequence: 3-cycle tone, rest, end marker.
    loop_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    check_val("start_busy", 32'(busy), 32'd1);
    bc = 1;
    for (int i = 0; i < 39; i++) begin tick(); if (busy) bc++; end
    check_val("seq_busy_cycles", 32'(bc), 32'd33);

    // Looping: entry 0 comes back every 33 cycles.
    loop_en = 1'b1; last = -1; wraps = 0; prev = 0;
    for (int c = 0; c < 102; c++) begin
      start = (c == 0);
      tick();
      if (busy && note_idx == 0 && prev != 0) begin
        if (last >= 0) check_val("loop_period", 32'(c - last), 32'd33);
        last = c; wraps++;
      end
      prev = int'(note_idx);
    end
    start = 1'b0;
    check_val("loop_wraps", 32'(wraps), 32'd3);
    stop = 1'b1; tick(); stop = 1'b0;

    // Rewrite of the playing entry takes effect on its next load only.
    start = 1'b1; tick(); start = 1'b0;
    repeat (5) tick();
    write_entry(0, 7, 2);
    check_val("keep_div3", 32'(speaker), 32'd1);
    n = 0; prev = int'(note_idx);
    while (n < 40 && !(note_idx == 0 && prev != 0)) begin prev = int'(note_idx); tick(); n++; end
    check_val("reload_reached", 32'(n < 40), 32'd1);
    repeat (8) tick();
    check_val("rewrite_div7", 32'(speaker), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    write_entry(0, 3, 2);

    // Stop mid-note, then start+stop together.
    loop_en = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (25) tick();
    check_val("mid_entry1", 32'(note_idx), 32'd1);
    stop = 1'b1; tick(); stop = 1'b0;
    check_val("stop_busy", 32'(busy), 32'd0);
    check_val("stop_idx", 32'(note_idx), 32'd0);
    check_val("stop_spk", 32'(speaker), 32'd0);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    check_val("start_stop_idle", 32'(busy), 32'd0);
    tick();

    // Reset mid-note keeps the table.
    start = 1'b1; tick(); start = 1'b0;
    repeat (10) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check_val("mid_rst_busy", 32'(busy), 32'd0);
    check_val("mid_rst_spk", 32'(speaker), 32'd0);
    play_count(bc);
    check_val("post_rst_cycles", 32'(bc), 32'd33);

    // Four live entries without loop: wraps past the last slot to IDLE.
    for (int a = 0; a < NOTES; a++) write_entry(a, $urandom_range(0, 4), $urandom_range(1, 2));
    start = 1'b1; tick(); start = 1'b0;
    seen3 = 0; n = 0;
    while (busy && n < 200) begin tick(); n++; if (busy && note_idx == 3) seen3 = 1; end
    check_val("saw_last_entry", 32'(seen3), 32'd1);
    run_until_idle(10);

    // Randomized traffic: writes, stops and starts at arbitrary times.
    for (int r = 0; r < 25; r++) begin
      for (int a = 0; a < NOTES; a++) write_entry(a, $urandom_range(0, 5), $urandom_range(0, 3));
      loop_en = 1'($urandom_range(0, 1));
      start = 1'b1; tick(); start = 1'b0;
      for (int c = 0; c < 80; c++) begin
        wr_en   = ($urandom_range(0, 7) == 0);
        wr_addr = AW'($urandom_range(0, NOTES - 1));
        wr_div  = DIV_W'($urandom_range(0, 5));
        wr_dur  = DUR_W'($urandom_range(0, 3));
        stop    = ($urandom_range(0, 49) == 0);
        start   = ($urandom_range(0, 11) == 0);
        tick();
      end
      wr_en = 1'b0; start = 1'b0;
      stop = 1'b1; tick(); stop = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
